// File: rtl/inst_pack.sv
// inst_pack: packs opcode/type fields into an instruction word and buffers
// the packed words in a small FIFO with a valid/ready interface on each side.
module inst_pack #(
  parameter int unsigned op_size = 4,
  parameter int unsigned param_a = 4,
  parameter int unsigned param_b = 4,
  parameter int unsigned param_c = param_a + param_b,
  parameter int unsigned cost_op = 3,
  parameter int unsigned depth   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [op_size-1:0]          in_op,
  input  logic [param_a-1:0]          in_act_type,
  input  logic [param_b-1:0]          in_dense_type,
  input  logic [param_c-1:0]          in_cost_type,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [op_size+param_c-1:0]  out_code,
  output logic [$clog2(depth):0]      level,
  output logic [15:0]                 sent_count
);

  localparam int unsigned code_size = op_size + param_c;
  localparam int unsigned lvl_w     = $clog2(depth) + 1;
  localparam int unsigned ptr_w     = $clog2(depth);

  // An out-of-range cost opcode can never match any op_size-bit opcode.
  localparam bit cost_ok = (op_size >= 32) || (cost_op < (32'd1 << op_size));
  localparam logic [op_size-1:0] cost_op_w = op_size'(cost_op);
  localparam logic [lvl_w-1:0]   depth_l   = lvl_w'(depth);

  logic [code_size-1:0] r_mem [depth];
  logic [ptr_w-1:0]     r_wr_ptr;
  logic [ptr_w-1:0]     r_rd_ptr;
  logic [lvl_w-1:0]     r_level;
  logic [15:0]          r_sent;

  logic                 w_is_cost;
  logic [param_c-1:0]   w_field;
  logic [code_size-1:0] w_code;
  logic                 w_push;
  logic                 w_pop;

  // Handshake status comes only from registered occupancy.
  assign in_ready   = (r_level != depth_l);
  assign out_valid  = (r_level != '0);
  assign level      = r_level;
  assign sent_count = r_sent;
  assign out_code   = r_mem[r_rd_ptr];

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign w_is_cost = cost_ok && (in_op == cost_op_w);

  // Operand field: cost type for the cost opcode, else activation over dense.
  always_comb begin
    w_field = '0;
    if (w_is_cost) begin
      w_field = in_cost_type;
    end else begin
      w_field[param_c-1 -: param_a] = in_act_type;
      w_field[param_b-1:0]          = in_dense_type;
    end
  end

  assign w_code = {in_op, w_field};

  // Word storage; written at push time, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  // Pointers, occupancy and popped-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_sent   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ptr_w'(1);
        r_sent   <= r_sent + 16'd1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + lvl_w'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - lvl_w'(1);
      end
    end
  end

endmodule
